// File: rtl/dma_requester.sv
// dma_requester: processor-side initiator for the shared-memory DMA engine.
// Optional WAIT abort counter is enabled by defining DMA_REQ_TIMEOUT_EN.
module dma_requester #(
    parameter int SIZE      = 4,
    parameter int PAGE_SIZE = 2,
    parameter int PROCSIZE  = 4,
    parameter int WORD_SIZE = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_action,
    input  logic [SIZE-1:0]           req_ptr,
    input  logic [PROCSIZE-1:0]       req_start,
    input  logic [PROCSIZE-1:0]       req_length,
    output logic                      done,
    output logic [SIZE-PAGE_SIZE-1:0] done_ptr,
    output logic                      err,
    output logic                      busy,
    output logic                      trigger,
    input  logic                      ack,
    output logic                      action,
    output logic [SIZE-1:0]           ptr,
    output logic [PROCSIZE-1:0]       copy_start,
    output logic [PROCSIZE-1:0]       copy_length,
    input  logic [SIZE-PAGE_SIZE-1:0] ptr_in,
    input  logic                      core_mem_en,
    input  logic                      core_mem_rw,
    input  logic [PROCSIZE-1:0]       core_mem_addr,
    input  logic [WORD_SIZE-1:0]      core_mem_wdata,
    output logic                      core_stall,
    input  logic                      dma_mem_rw,
    input  logic [PROCSIZE-1:0]       dma_mem_addr,
    input  logic [WORD_SIZE-1:0]      dma_mem_wdata,
    output logic                      mem_rw,
    output logic [PROCSIZE-1:0]       mem_addr,
    output logic [WORD_SIZE-1:0]      mem_wdata
);

    localparam logic [PROCSIZE:0] DEPTH = {1'b1, {PROCSIZE{1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state;
    state_t            state_n;
    logic              ack_last;
    logic              zero_len;
    logic              range_bad;
    logic              launch;
    logic              ack_seen;
    logic              abort;
    logic              expired;
    logic [PROCSIZE:0] end_addr;

    assign end_addr  = {1'b0, req_start} + {1'b0, req_length};
    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE);

`ifdef DMA_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // expires on the last of TIMEOUT WAIT cycles
    assign expired = (wait_cnt == CW'(TIMEOUT - 1));
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        zero_len  = 1'b0;
        range_bad = 1'b0;
        launch    = 1'b0;
        ack_seen  = 1'b0;
        abort     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    unique case (1'b1)
                        (req_length == '0): zero_len  = 1'b1;
                        (end_addr > DEPTH): range_bad = 1'b1;
                        default: begin
                            launch  = 1'b1;
                            state_n = ISSUE;
                        end
                    endcase
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (ack != ack_last) begin
                    ack_seen = 1'b1;
                    state_n  = IDLE;
                end else if (expired) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trigger     <= 1'b0;
            action      <= 1'b0;
            ptr         <= '0;
            copy_start  <= '0;
            copy_length <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            done_ptr    <= '0;
            ack_last    <= 1'b0;
        end else begin
            done <= ack_seen | zero_len;
            err  <= range_bad | abort;
            // stale toggles seen while idle are absorbed here
            if (state == IDLE || ack_seen || abort) begin
                ack_last <= ack;
            end
            if (launch) begin
                action      <= req_action;
                ptr         <= req_ptr;
                copy_start  <= req_start;
                copy_length <= req_length;
            end
            if (state == ISSUE) begin
                trigger <= ~trigger;
            end
            if (ack_seen) begin
                done_ptr <= ptr_in;
            end
        end
    end

    assign core_stall = busy & core_mem_en;
    assign mem_rw     = busy ? dma_mem_rw    : core_mem_rw;
    assign mem_addr   = busy ? dma_mem_addr  : core_mem_addr;
    assign mem_wdata  = busy ? dma_mem_wdata : core_mem_wdata;

endmodule

// File: tb/tb_dma_requester.sv
// tb_dma_requester: directed bench with a done/err scoreboard for dma_requester.
// Timeout branch is exercised when DMA_REQ_TIMEOUT_EN is defined.
module tb_dma_requester;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_action;
    logic [3:0]  req_ptr;
    logic [3:0]  req_start;
    logic [3:0]  req_length;
    logic        done;
    logic [1:0]  done_ptr;
    logic        err;
    logic        busy;
    logic        trigger;
    logic        ack;
    logic        action;
    logic [3:0]  ptr;
    logic [3:0]  copy_start;
    logic [3:0]  copy_length;
    logic [1:0]  ptr_in;
    logic        core_mem_en;
    logic        core_mem_rw;
    logic [3:0]  core_mem_addr;
    logic [15:0] core_mem_wdata;
    logic        core_stall;
    logic        dma_mem_rw;
    logic [3:0]  dma_mem_addr;
    logic [15:0] dma_mem_wdata;
    logic        mem_rw;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;

    typedef struct {
        logic       is_err;
        logic [1:0] ptr;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    logic exp_trig;

    dma_requester #(.TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_action(req_action), .req_ptr(req_ptr),
        .req_start(req_start), .req_length(req_length),
        .done(done), .done_ptr(done_ptr), .err(err), .busy(busy),
        .trigger(trigger), .ack(ack), .action(action), .ptr(ptr),
        .copy_start(copy_start), .copy_length(copy_length),
        .ptr_in(ptr_in),
        .core_mem_en(core_mem_en), .core_mem_rw(core_mem_rw),
        .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata),
        .core_stall(core_stall),
        .dma_mem_rw(dma_mem_rw), .dma_mem_addr(dma_mem_addr),
        .dma_mem_wdata(dma_mem_wdata),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // every done/err pulse must match the oldest queued expectation
    always @(negedge clock) begin
        if (done || err) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got done=%b err=%b want none",
                         done, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (err !== e.is_err || done !== !e.is_err ||
                    (done && done_ptr !== e.ptr)) begin
                    errors++;
                    $display("FAIL pulse got done=%b err=%b ptr=%0d want err=%b ptr=%0d",
                             done, err, done_ptr, e.is_err, e.ptr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_pulse(input logic is_err, input logic [1:0] p);
        exp_t e;
        e.is_err = is_err;
        e.ptr    = p;
        sb.push_back(e);
    endtask

    task automatic issue(input logic a, input logic [3:0] p,
                         input logic [3:0] s, input logic [3:0] l);
        req_valid  = 1'b1;
        req_action = a;
        req_ptr    = p;
        req_start  = s;
        req_length = l;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic launch(input string name, input logic a,
                          input logic [3:0] p, input logic [3:0] s,
                          input logic [3:0] l);
        issue(a, p, s, l);
        chk({name, "_busy"}, busy, 1);
        chk({name, "_ready"}, req_ready, 0);
        chk({name, "_action"}, action, a);
        chk({name, "_ptr"}, ptr, p);
        chk({name, "_start"}, copy_start, s);
        chk({name, "_len"}, copy_length, l);
        chk({name, "_trig_hold"}, trigger, exp_trig);
        step();
        exp_trig = ~exp_trig;
        chk({name, "_trig_tog"}, trigger, exp_trig);
    endtask

    task automatic complete(input string name, input logic [1:0] p);
        ptr_in = p;
        ack    = ~ack;
        expect_pulse(1'b0, p);
        step();
        chk({name, "_busy_fall"}, busy, 0);
        chk({name, "_ready"}, req_ready, 1);
        chk({name, "_done_ptr"}, done_ptr, p);
        step();
        chk({name, "_done_low"}, done, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_trig = 1'b0;
        reset = 1'b1;
        req_valid = 0; req_action = 0; req_ptr = 0;
        req_start = 0; req_length = 0;
        ack = 0; ptr_in = 0;
        core_mem_en = 0; core_mem_rw = 0;
        core_mem_addr = 0; core_mem_wdata = 0;
        dma_mem_rw = 0; dma_mem_addr = 0; dma_mem_wdata = 0;
        repeat (2) step();
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_trig", trigger, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_done_ptr", done_ptr, 0);
        reset = 1'b0;
        step();

        // WRITE 2..4
        launch("wr", 1'b1, 4'd0, 4'd2, 4'd3);
        repeat (3) step();
        chk("wr_wait_busy", busy, 1);
        complete("wr", 2'd3);

        // READ with memory hand-over while waiting
        launch("rd", 1'b0, 4'd5, 4'd0, 4'd4);
        core_mem_en = 1; core_mem_rw = 0;
        core_mem_addr = 4'd9; core_mem_wdata = 16'haaaa;
        dma_mem_rw = 1; dma_mem_addr = 4'd6; dma_mem_wdata = 16'h1234;
        #1;
        chk("rd_stall", core_stall, 1);
        chk("rd_mem_addr", mem_addr, 6);
        chk("rd_mem_wdata", mem_wdata, 16'h1234);
        chk("rd_mem_rw", mem_rw, 1);
        repeat (3) step();
        chk("rd_ptr_held", ptr, 5);
        complete("rd", 2'd1);
        chk("core_stall_off", core_stall, 0);
        chk("core_mem_addr", mem_addr, 9);
        chk("core_mem_wdata", mem_wdata, 16'haaaa);
        chk("core_mem_rw", mem_rw, 0);
        core_mem_en = 0;

        // zero length: done only, pointer kept
        expect_pulse(1'b0, 2'd1);
        issue(1'b1, 4'd0, 4'd3, 4'd0);
        chk("zero_busy", busy, 0);
        step();
        chk("zero_trig", trigger, exp_trig);
        chk("zero_done_ptr", done_ptr, 1);

        // out of range: 14+3 = 17 > 16
        expect_pulse(1'b1, 2'd0);
        issue(1'b0, 4'd0, 4'd14, 4'd3);
        chk("range_busy", busy, 0);
        step();
        chk("range_trig", trigger, exp_trig);

        // exact fit: 13+3 = 16 is legal
        launch("edge", 1'b1, 4'd0, 4'd13, 4'd3);
        complete("edge", 2'd2);

        // stale ack toggle in IDLE must be ignored
        ack = ~ack;
        repeat (2) step();
        launch("stale", 1'b0, 4'd7, 4'd0, 4'd1);
        repeat (4) step();
        chk("stale_busy", busy, 1);
        complete("stale", 2'd0);

        // asynchronous reset while waiting
        launch("abort", 1'b1, 4'd3, 4'd1, 4'd2);
        step();
        #2;
        reset = 1'b1;
        ack = 1'b0;
        #1;
        exp_trig = 1'b0;
        chk("ar_trig", trigger, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ready", req_ready, 1);
        chk("ar_action", action, 0);
        chk("ar_len", copy_length, 0);
        chk("ar_done_ptr", done_ptr, 0);
        step();
        reset = 1'b0;
        repeat (2) step();

`ifdef DMA_REQ_TIMEOUT_EN
        launch("tmo", 1'b0, 4'd1, 4'd0, 4'd2);
        expect_pulse(1'b1, 2'd0);
        repeat (7) step();
        chk("tmo_busy_before", busy, 1);
        step();
        chk("tmo_busy_after", busy, 0);
        chk("tmo_ready", req_ready, 1);
        step();
        chk("tmo_trig", trigger, exp_trig);
`else
        launch("hang", 1'b0, 4'd1, 4'd0, 4'd2);
        repeat (1000) step();
        chk("hang_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_trig = 1'b0;
        step();
`endif
        repeat (2) step();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
